// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - zero-crossing triggered capture of 256 samples into a double-buffered RAM
module wave_capture #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [8:0]          write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] index;
  logic       prev_neg;
  logic       sample_neg;
  logic [7:0] sample_offset;

  assign sample_neg    = new_sample_in[SAMPLE_W-1];
  assign sample_offset = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2 -: 7]};

  // Low-order sample bits below the 8 kept for display are intentionally dropped.
  generate
    if (SAMPLE_W > 8) begin : g_low_bits
      logic unused_low_bits;
      assign unused_low_bits = ^new_sample_in[SAMPLE_W-9:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ARMED;
      index         <= 8'd0;
      prev_neg      <= 1'b0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= 9'd0;
      write_sample  <= 8'd0;
    end else begin
      write_enable <= 1'b0;
      if (new_sample_ready) begin
        prev_neg <= sample_neg;
      end
      case (state)
        ARMED: begin
          if (new_sample_ready && prev_neg && !sample_neg) begin
            state <= ACTIVE;
            index <= 8'd0;
          end
        end
        ACTIVE: begin
          if (new_sample_ready) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, index};
            write_sample  <= sample_offset;
            index         <= index + 8'd1;
            if (index == 8'hFF) begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // Swap halves only during vertical blank so the display never sees a torn frame.
          if (wave_display_idle) begin
            read_index <= ~read_index;
            state      <= ARMED;
          end
        end
        default: begin
          state <= ARMED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture.sv
// tb/tb_wave_capture.sv - directed self-checking bench for wave_capture
module tb_wave_capture;

  logic        clk;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int assert_count;
  int fail_count;
  int write_seen;

  wave_capture #(.SAMPLE_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .wave_display_idle(wave_display_idle),
    .write_address    (write_address),
    .write_enable     (write_enable),
    .write_sample     (write_sample),
    .read_index       (read_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One strobe; returns 1 ns after the capturing edge so registered outputs are settled.
  task automatic pulse(input logic [15:0] v);
    new_sample_ready = 1'b1;
    new_sample_in    = v;
    @(posedge clk);
    #1;
    new_sample_ready = 1'b0;
  endtask

  task automatic idle_cycle();
    wave_display_idle = 1'b1;
    @(posedge clk);
    #1;
    wave_display_idle = 1'b0;
  endtask

  logic [17:0] exp_w;
  logic [15:0] rnd;

  initial begin
    assert_count      = 0;
    fail_count        = 0;
    reset             = 1'b0;
    new_sample_ready  = 1'b0;
    new_sample_in     = 16'h0000;
    wave_display_idle = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check_val("rst_we",   {31'd0, write_enable}, 32'd0);
    check_val("rst_addr", {23'd0, write_address}, 32'd0);
    check_val("rst_ws",   {24'd0, write_sample}, 32'd0);
    check_val("rst_ri",   {31'd0, read_index}, 32'd0);

    // Positive crossing: the crossing sample itself is not stored.
    pulse(16'hFF9C);
    check_val("arm_neg_we", {31'd0, write_enable}, 32'd0);
    pulse(16'h0032);
    check_val("arm_cross_we", {31'd0, write_enable}, 32'd0);
    pulse(16'h1234);
    check_val("first_we",   {31'd0, write_enable}, 32'd1);
    check_val("first_addr", {23'd0, write_address}, 32'h100);
    check_val("first_ws",   {24'd0, write_sample}, 32'h92);

    for (int i = 1; i < 256; i++) begin
      pulse({i[7:0], 8'h00});
      exp_w = {1'b1, 1'b1, i[7:0], i[7:0] ^ 8'h80};
      check_val("cap0", {14'd0, write_enable, write_address, write_sample}, {14'd0, exp_w});
    end

    // Now in WAIT: sample ignored, outputs held.
    pulse(16'h8000);
    check_val("wait_we",   {31'd0, write_enable}, 32'd0);
    check_val("wait_ri",   {31'd0, read_index}, 32'd0);
    check_val("hold_addr", {23'd0, write_address}, 32'h1FF);
    check_val("hold_ws",   {24'd0, write_sample}, 32'h7F);

    idle_cycle();
    check_val("swap_ri", {31'd0, read_index}, 32'd1);

    // prev_neg from the WAIT sample arms an immediate trigger.
    pulse(16'h0100);
    check_val("cross2_we", {31'd0, write_enable}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      pulse({i[7:0], 8'h00});
      exp_w = {1'b1, 1'b0, i[7:0], i[7:0] ^ 8'h80};
      check_val("cap1", {14'd0, write_enable, write_address, write_sample}, {14'd0, exp_w});
    end

    // WAIT with idle and a coinciding positive sample after a negative one: no write, no trigger.
    new_sample_ready  = 1'b1;
    new_sample_in     = 16'h0500;
    wave_display_idle = 1'b1;
    @(posedge clk);
    #1;
    new_sample_ready  = 1'b0;
    wave_display_idle = 1'b0;
    check_val("coinc_we", {31'd0, write_enable}, 32'd0);
    check_val("coinc_ri", {31'd0, read_index}, 32'd0);
    pulse(16'h0600);
    check_val("coinc_next_we", {31'd0, write_enable}, 32'd0);
    pulse(16'h0700);
    check_val("coinc_next2_we", {31'd0, write_enable}, 32'd0);

    // Non-negative only: never triggers.
    write_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      rnd = 16'($urandom_range(0, 32'h7FFF));
      pulse(rnd);
      if (write_enable) write_seen++;
    end
    check_val("nonneg_writes", write_seen, 32'd0);

    // Capture with display idle held high throughout ACTIVE, then reset mid-capture.
    pulse(16'hFFFF);
    pulse(16'h0001);
    wave_display_idle = 1'b1;
    for (int i = 0; i < 100; i++) begin
      pulse(16'h2000);
    end
    check_val("act_idle_addr", {23'd0, write_address}, 32'h163);
    check_val("act_idle_ri",   {31'd0, read_index}, 32'd0);
    wave_display_idle = 1'b0;
    reset            = 1'b0;
    new_sample_ready = 1'b1;
    new_sample_in    = 16'h3000;
    @(posedge clk);
    #1;
    reset            = 1'b1;
    new_sample_ready = 1'b0;
    check_val("abort_we",   {31'd0, write_enable}, 32'd0);
    check_val("abort_ri",   {31'd0, read_index}, 32'd0);
    check_val("abort_addr", {23'd0, write_address}, 32'd0);
    pulse(16'h0010);
    check_val("post_rst_pos_we", {31'd0, write_enable}, 32'd0);
    pulse(16'h8000);
    pulse(16'h0010);
    check_val("post_rst_cross_we", {31'd0, write_enable}, 32'd0);
    pulse(16'h4000);
    check_val("restart", {14'd0, write_enable, write_address, write_sample}, {14'd0, 1'b1, 9'h100, 8'hC0});
    @(posedge clk);
    #1;
    check_val("restart_one_cycle", {31'd0, write_enable}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 Parameter SAMPLE_W, default 16: width of the signed two's-complement input sample; SHALL be at least 8.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-004 new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid in that cycle.
REQ-005 new_sample_in  input  SAMPLE_W  signed audio sample.
REQ-006 wave_display_idle  input  1  high while the display is outside the active raster (vertical blank).
REQ-007 write_address  output  9  sample RAM write address, {~read_index, index[7:0]}.
REQ-008 write_enable  output  1  one-cycle RAM write strobe.
REQ-009 write_sample  output  8  unsigned-offset sample: {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]}.
REQ-010 read_index  output  1  selects the RAM half the display reads; capture always writes the other half.

Function
REQ-011 Three states SHALL exist: ARMED, ACTIVE, WAIT.
REQ-012 A sign register prev_neg SHALL load new_sample_in[SAMPLE_W-1] on every new_sample_ready, in all states.
REQ-013 ARMED: new_sample_ready with prev_neg=1 and current MSB=0 (positive zero crossing) -> ACTIVE, index=0; the crossing sample SHALL NOT be written.
REQ-014 ARMED: new_sample_ready without crossing -> remain ARMED, no write.
REQ-015 ACTIVE: each new_sample_ready SHALL write the sample at {~read_index, index}, then increment index.
REQ-016 ACTIVE: the write with index=255 SHALL be the last one; state -> WAIT, index wraps to 0.
REQ-017 WAIT: new_sample_ready SHALL be ignored except for the prev_neg update; no write.
REQ-018 WAIT with wave_display_idle=1 -> toggle read_index, state -> ARMED, in the same clock edge.
REQ-019 wave_display_idle SHALL be ignored in ARMED and ACTIVE; read_index changes only per REQ-018.
REQ-020 write_enable, write_address and write_sample SHALL be registered: asserted exactly the cycle after the accepted new_sample_ready, for one cycle.
REQ-021 write_address and write_sample SHALL hold their last values when write_enable=0.
REQ-022 In WAIT, a new_sample_ready coinciding with wave_display_idle=1 SHALL NOT be written and SHALL NOT be evaluated for a trigger; it SHALL update prev_neg.
REQ-023 The first sample after entering ARMED MAY trigger using the prev_neg captured in WAIT.
REQ-024 Back-to-back new_sample_ready on consecutive cycles SHALL each be handled without loss.

Reset
REQ-025 When reset=0 at a rising edge: state=ARMED, index=0, prev_neg=0, read_index=0, write_enable=0, write_address=0, write_sample=0.
REQ-026 Reset SHALL abort any in-progress capture or wait without further writes; the partially written half is not cleaned.
REQ-027 Reset SHALL override all other inputs in the same cycle.

Verification
REQ-028 Reset held 2 cycles, then released -> all outputs 0, state ARMED.
REQ-029 ARMED, samples 0xFF9C then 0x0032, then 0x1234 -> no write for the first two; one cycle after 0x1234: write_enable=1, write_address=0x100, write_sample=0x92.
REQ-030 After the trigger, 256 samples -> writes to 0x100..0x1FF in order, then WAIT; a 257th sample -> no write, read_index stays 0.
REQ-031 In WAIT, wave_display_idle=1 for one cycle -> read_index=1 the next cycle; a new crossing -> writes to 0x000..0x0FF.
REQ-032 Only non-negative samples (0x0000..0x7FFF), 1000 strobes -> write_enable never asserted.
REQ-033 Reset driven low after 100 ACTIVE writes -> write_enable=0 the next cycle, read_index=0, ARMED; the next crossing restarts writes at 0x100.
